// File: rtl/playfield_renderer.sv
`default_nettype none
// ============================================================================
// Module      : playfield_renderer
// Description : Draws four table walls and an optional dashed centre net; each
//               wall blinks for FLASH_FRAMES frames after a hit pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module playfield_renderer #(
    parameter int LEFT         = 40,
    parameter int RIGHT        = 600,
    parameter int TOP          = 40,
    parameter int BOTTOM       = 440,
    parameter int BORDER_W     = 4,
    parameter int NET_X        = 318,
    parameter int NET_W        = 4,
    parameter int DASH_LOG2    = 3,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        frame_start,
    input  logic [3:0]  hit,
    input  logic        net_en,
    output logic        wall_valid,
    output logic        net_valid,
    output logic        pixel_valid,
    output logic [3:0]  flashing
);

    localparam logic [10:0] c_l_lo     = 11'(LEFT - BORDER_W);
    localparam logic [10:0] c_l_hi     = 11'(LEFT);
    localparam logic [10:0] c_r_lo     = 11'(RIGHT);
    localparam logic [10:0] c_r_hi     = 11'(RIGHT + BORDER_W);
    localparam logic [10:0] c_t_lo     = 11'(TOP - BORDER_W);
    localparam logic [10:0] c_t_hi     = 11'(TOP);
    localparam logic [10:0] c_b_lo     = 11'(BOTTOM);
    localparam logic [10:0] c_b_hi     = 11'(BOTTOM + BORDER_W);
    localparam logic [10:0] c_net_x_lo = 11'(NET_X);
    localparam logic [10:0] c_net_x_hi = 11'(NET_X + NET_W - 1);
    localparam logic [10:0] c_net_v_lo = 11'(TOP + 1);
    localparam logic [10:0] c_net_v_hi = 11'(BOTTOM - 1);
    localparam logic [7:0]  c_flash    = 8'(FLASH_FRAMES);

    logic        w_h_span;
    logic        w_v_span;
    logic [3:0]  w_in_wall;
    logic [3:0]  w_shown;
    logic        w_wall;
    logic        w_net;
    logic [10:0] w_vrel;
    logic        r_wall;
    logic        r_net;
    logic        r_pix;

    assign w_h_span = (hcount >= c_l_lo) && (hcount <= c_r_hi);
    assign w_v_span = (vcount >= c_t_lo) && (vcount <= c_b_hi);

    assign w_in_wall[0] = (hcount >= c_l_lo) && (hcount <= c_l_hi) && w_v_span;
    assign w_in_wall[1] = (hcount >= c_r_lo) && (hcount <= c_r_hi) && w_v_span;
    assign w_in_wall[2] = (vcount >= c_t_lo) && (vcount <= c_t_hi) && w_h_span;
    assign w_in_wall[3] = (vcount >= c_b_lo) && (vcount <= c_b_hi) && w_h_span;

    // A corner pixel stays lit while any wall covering it is in its visible phase.
    assign w_wall = |(w_in_wall & w_shown);

    // Dash phase is measured from the top wall so every court starts with a dash.
    assign w_vrel = vcount - c_t_hi;
    assign w_net  = net_en
                 && (hcount >= c_net_x_lo) && (hcount <= c_net_x_hi)
                 && (vcount >= c_net_v_lo) && (vcount <= c_net_v_hi)
                 && !w_vrel[DASH_LOG2];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_flash
            logic [7:0] r_cnt;

            // A hit reloads the counter even mid-blink and overrides the frame tick.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 8'd0;
                end else if (hit[i]) begin
                    r_cnt <= c_flash;
                end else if (frame_start && (r_cnt != 8'd0)) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            assign w_shown[i]  = (r_cnt == 8'd0) || r_cnt[0];
            assign flashing[i] = (r_cnt != 8'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wall <= 1'b0;
            r_net  <= 1'b0;
            r_pix  <= 1'b0;
        end else begin
            r_wall <= w_wall;
            r_net  <= w_net;
            r_pix  <= w_wall | w_net;
        end
    end

    assign wall_valid  = r_wall;
    assign net_valid   = r_net;
    assign pixel_valid = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_playfield_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_playfield_renderer
// Description : Scoreboard bench for playfield_renderer (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playfield_renderer;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        frame_start;
    logic [3:0]  hit;
    logic        net_en;
    logic        wall_valid;
    logic        net_valid;
    logic        pixel_valid;
    logic [3:0]  flashing;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         m_cnt[4];

    playfield_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .frame_start (frame_start),
        .hit         (hit),
        .net_en      (net_en),
        .wall_valid  (wall_valid),
        .net_valid   (net_valid),
        .pixel_valid (pixel_valid),
        .flashing    (flashing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall extents written out from the default geometry.
    function automatic logic [3:0] in_walls(input int h, input int v);
        logic [3:0] r;
        r[0] = (h >= 36)  && (h <= 40)  && (v >= 36) && (v <= 444);
        r[1] = (h >= 600) && (h <= 604) && (v >= 36) && (v <= 444);
        r[2] = (v >= 36)  && (v <= 40)  && (h >= 36) && (h <= 604);
        r[3] = (v >= 440) && (v <= 444) && (h >= 36) && (h <= 604);
        return r;
    endfunction

    function automatic logic in_net(input int h, input int v, input logic ne);
        return ne && (h >= 318) && (h <= 321) && (v >= 41) && (v <= 439)
               && (((v - 40) & 8) == 0);
    endfunction

    // One pixel clock of stimulus; the expected registered response is queued.
    task automatic step(input int h, input int v, input logic fs,
                        input logic [3:0] hv, input logic ne, input logic rs,
                        input string tag);
        logic [3:0] inw;
        logic [3:0] shown;
        logic       w;
        logic       n;
        logic [3:0] fl;
        @(negedge clk);
        hcount      = 11'(h);
        vcount      = 11'(v);
        frame_start = fs;
        hit         = hv;
        net_en      = ne;
        rst         = rs;
        if (rs) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            exp_q.push_back(7'b0);
        end else begin
            inw = in_walls(h, v);
            for (int i = 0; i < 4; i++) shown[i] = (m_cnt[i] == 0) || (m_cnt[i] % 2 == 1);
            w = |(inw & shown);
            n = in_net(h, v, ne);
            for (int i = 0; i < 4; i++) begin
                if (hv[i]) m_cnt[i] = 8;
                else if (fs && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                fl[i] = (m_cnt[i] != 0);
            end
            exp_q.push_back({w, n, w | n, fl});
        end
        tag_q.push_back(tag);
    endtask

    // Monitor: each queued expectation is due one clock after its inputs.
    initial begin
        logic [6:0] e;
        logic [6:0] a;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {wall_valid, net_valid, pixel_valid, flashing};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s h=%0d v=%0d: got wall/net/pix/flash=%b/%b/%b/%b required %b/%b/%b/%b",
                             t, hcount, vcount, a[6], a[5], a[4], a[3:0], e[6], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, required finish before 5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int rows[11] = '{0, 35, 36, 40, 41, 200, 439, 440, 444, 445, 524};
        int cols[10] = '{35, 36, 40, 41, 318, 599, 600, 604, 605, 799};
        rst = 1'b1; hcount = '0; vcount = '0; frame_start = 1'b0; hit = '0; net_en = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        // Reset, including a hit and in-wall pixels that must be ignored.
        step(38, 100, 1'b0, 4'b0000, 1'b0, 1'b1, "reset");
        step(38, 38,  1'b1, 4'b1111, 1'b1, 1'b1, "reset_hit");
        step(0,  0,   1'b0, 4'b0000, 1'b0, 1'b1, "reset");
        step(0,  0,   1'b0, 4'b0000, 1'b0, 1'b0, "release");

        // Frame sweep: full rows and columns through every edge.
        foreach (rows[r]) for (int h = 0; h < 800; h++)
            step(h, rows[r], 1'b0, 4'b0000, 1'b0, 1'b0, "sweep_row");
        foreach (cols[c]) for (int v = 0; v < 525; v++)
            step(cols[c], v, 1'b0, 4'b0000, 1'b0, 1'b0, "sweep_col");

        // Left-wall blink over eight frames.
        step(0, 0, 1'b0, 4'b0001, 1'b0, 1'b0, "hit_left");
        for (int f = 0; f < 8; f++) begin
            step(38,  100, 1'b0, 4'b0000, 1'b0, 1'b0, "blink_left");
            step(38,  38,  1'b0, 4'b0000, 1'b0, 1'b0, "blink_corner");
            step(602, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "blink_right");
            step(200, 442, 1'b0, 4'b0000, 1'b0, 1'b0, "blink_bottom");
            step(0,   0,   1'b1, 4'b0000, 1'b0, 1'b0, "frame_start");
        end
        step(38, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "left_done");

        // Top wall: reach count 3, then hit and frame_start together.
        step(0, 0, 1'b0, 4'b0100, 1'b0, 1'b0, "hit_top");
        for (int f = 0; f < 5; f++) step(0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, "frame_start");
        step(200, 38, 1'b0, 4'b0000, 1'b0, 1'b0, "top_cnt3");
        step(0, 0, 1'b1, 4'b0100, 1'b0, 1'b0, "load_wins");
        for (int f = 0; f < 9; f++) begin
            step(200, 38, 1'b0, 4'b0000, 1'b0, 1'b0, "blink_top");
            step(0,   0,  1'b1, 4'b0000, 1'b0, 1'b0, "frame_start");
        end
        step(200, 38, 1'b0, 4'b0000, 1'b0, 1'b0, "top_done");

        // Dashed net, enabled then disabled.
        for (int e = 1; e >= 0; e--)
            for (int v = 39; v <= 65; v++)
                for (int h = 317; h <= 322; h++)
                    step(h, v, 1'b0, 4'b0000, logic'(e), 1'b0, "net");
        step(320, 439, 1'b0, 4'b0000, 1'b1, 1'b0, "net_bottom");
        step(320, 440, 1'b0, 4'b0000, 1'b1, 1'b0, "net_below");

        // Reset mid-blink of the right wall, then a corner with only R hidden.
        step(0, 0, 1'b0, 4'b0010, 1'b0, 1'b0, "hit_right");
        for (int f = 0; f < 3; f++) step(0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, "frame_start");
        step(602, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "right_cnt5");
        step(602, 100, 1'b0, 4'b0000, 1'b0, 1'b1, "abort_reset");
        step(602, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "after_abort");
        step(602, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "after_abort");
        step(0, 0, 1'b0, 4'b0010, 1'b0, 1'b0, "hit_right");
        step(600, 40,  1'b0, 4'b0000, 1'b0, 1'b0, "corner_rt");
        step(600, 100, 1'b0, 4'b0000, 1'b0, 1'b0, "right_hidden");
        step(604, 444, 1'b0, 4'b0000, 1'b0, 1'b0, "corner_rb");
        step(0, 0, 1'b0, 4'b0011, 1'b0, 1'b0, "hit_lr");
        step(40, 40,  1'b0, 4'b0000, 1'b0, 1'b0, "corner_lt");
        step(200, 200, 1'b0, 4'b0000, 1'b0, 1'b0, "interior");

        // Drain the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
